// File: rtl/dmem_preload_loader.sv
// Byte-stream to word loader for the RV32I data-memory preload port.
// Holds the core until the requested number of words has been written.
module dmem_preload_loader #(
  parameter int               DPW       = 32,
  parameter int               ADW       = 32,
  parameter logic [ADW-1:0]   BASE_ADDR = '0,
  parameter int               MAX_WORDS = 1024
) (
  input  logic           clk,
  input  logic           srst,
  input  logic           start_i,
  input  logic [15:0]    num_words_i,
  input  logic           byte_valid_i,
  input  logic [7:0]     byte_data_i,
  output logic           byte_ready_o,
  output logic           data_en,
  output logic [ADW-1:0] input_addr,
  output logic [DPW-1:0] input_data,
  output logic           core_hold_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o
);

  localparam int BPW = DPW / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0]    word_idx_q, word_idx_d;
  logic [15:0]    count_q, count_d;
  logic [DPW-1:0] buf_q, buf_d;
  logic           ready_q, ready_d;
  logic           en_q, en_d;
  logic [ADW-1:0] addr_q, addr_d;
  logic [DPW-1:0] data_q, data_d;
  logic           hold_q, hold_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           hs;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    count_d    = count_q;
    buf_d      = buf_q;
    err_d      = 1'b0;
    en_d       = 1'b0;
    addr_d     = '0;
    data_d     = '0;
    hs         = byte_valid_i & ready_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (int'(num_words_i) > MAX_WORDS) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (num_words_i == 16'd0) begin
            state_d = DONE;
          end else begin
            state_d    = COLLECT;
            count_d    = num_words_i;
            byte_cnt_d = '0;
            word_idx_d = '0;
          end
        end
      end
      COLLECT: begin
        if (hs) begin
          for (int i = 0; i < BPW; i++) begin
            if (byte_cnt_q == CW'(i)) buf_d[8*i +: 8] = byte_data_i;
          end
          // Last lane: launch the write on the very next cycle
          if (byte_cnt_q == CW'(BPW - 1)) begin
            byte_cnt_d = '0;
            state_d    = WRITE;
            en_d       = 1'b1;
            addr_d     = BASE_ADDR + (ADW'(word_idx_q) << 2);
            data_d     = buf_d;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_d == count_q) ? DONE : COLLECT;
      end
    endcase

    ready_d = (state_d == COLLECT);
    busy_d  = (state_d == COLLECT) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    hold_d  = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      count_q    <= '0;
      buf_q      <= '0;
      ready_q    <= 1'b0;
      en_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      hold_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
      ready_q    <= ready_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign data_en      = en_q;
  assign input_addr   = addr_q;
  assign input_data   = data_q;
  assign core_hold_o  = hold_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_dmem_preload_loader.sv
// Bench for dmem_preload_loader: two instances (base 0 and a
// wrapping base) share one byte stream; writes go through scoreboards.
module tb_dmem_preload_loader;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic        start;
  logic [15:0] num;
  logic        bv;
  logic [7:0]  bd;

  logic        rdy_a, en_a, hold_a, busy_a, done_a, err_a;
  logic [31:0] addr_a, data_a;
  logic        rdy_b, en_b, hold_b, busy_b, done_b, err_b;
  logic [31:0] addr_b, data_b;

  dmem_preload_loader #(
    .DPW(32), .ADW(32), .BASE_ADDR(32'h0), .MAX_WORDS(1024)
  ) dut_a (
    .clk(clk), .srst(srst), .start_i(start), .num_words_i(num),
    .byte_valid_i(bv), .byte_data_i(bd), .byte_ready_o(rdy_a),
    .data_en(en_a), .input_addr(addr_a), .input_data(data_a),
    .core_hold_o(hold_a), .busy_o(busy_a), .done_o(done_a),
    .err_o(err_a)
  );

  dmem_preload_loader #(
    .DPW(32), .ADW(32), .BASE_ADDR(32'hFFFF_FFFC), .MAX_WORDS(1024)
  ) dut_b (
    .clk(clk), .srst(srst), .start_i(start), .num_words_i(num),
    .byte_valid_i(bv), .byte_data_i(bd), .byte_ready_o(rdy_b),
    .data_en(en_b), .input_addr(addr_b), .input_data(data_b),
    .core_hold_o(hold_b), .busy_o(busy_b), .done_o(done_b),
    .err_o(err_b)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  bit          mon_en = 1'b0;
  logic        prev_a = 1'b0;
  logic        prev_b = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop one expected write per observed strobe
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] e;
      if (en_a === 1'b1) begin
        e = (qa.size() > 0) ? qa.pop_front() : 64'hx;
        chk("a_write", {addr_a, data_a}, e);
        chk("a_en_one_cycle", 64'(prev_a), 64'd0);
      end else begin
        chk("a_idle_bus", {addr_a, data_a}, 64'd0);
      end
      if (en_b === 1'b1) begin
        e = (qb.size() > 0) ? qb.pop_front() : 64'hx;
        chk("b_write", {addr_b, data_b}, e);
        chk("b_en_one_cycle", 64'(prev_b), 64'd0);
      end else begin
        chk("b_idle_bus", {addr_b, data_b}, 64'd0);
      end
      prev_a = en_a;
      prev_b = en_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    srst = 1'b1;
    repeat (n) tick();
    srst = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num   = n;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    acc = 1'b0;
    bv  = 1'b0;
    repeat (gap) tick();
    bv = 1'b1;
    bd = b;
    for (int k = 0; k < 40; k++) begin
      if (!acc) begin
        if (rdy_a === 1'b1) acc = 1'b1;
        tick();
      end
    end
    bv = 1'b0;
    chk("byte_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int idx,
                           input int gapmax);
    logic [31:0] off;
    off = 32'(idx) * 32'd4;
    qa.push_back({off, w});
    qb.push_back({32'hFFFF_FFFC + off, w});
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8],
                gapmax > 0 ? int'($urandom_range(0, gapmax)) : 0);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 40 && done_a !== 1'b1; k++) tick();
    chk(tag, 64'(done_a), 64'd1);
  endtask

  task automatic drained(input string tag);
    chk(tag, 64'(qa.size() + qb.size()), 64'd0);
  endtask

  initial begin
    srst  = 1'b1;
    start = 1'b0;
    num   = '0;
    bv    = 1'b0;
    bd    = '0;
    tick();

    // 1: reset state
    do_reset(2);
    chk("rst_hold", 64'(hold_a), 64'd1);
    chk("rst_en", 64'(en_a), 64'd0);
    chk("rst_ready", 64'(rdy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    mon_en = 1'b1;

    // 2: two words back-to-back, plus an ignored start while busy
    do_start(16'd2);
    chk("t2_busy", 64'(busy_a), 64'd1);
    chk("t2_ready", 64'(rdy_a), 64'd1);
    chk("t2_hold", 64'(hold_a), 64'd1);
    send_word(32'h0000_0005, 0, 0);
    chk("t2_latency", 64'(en_a), 64'd1);
    chk("t2_ready_in_write", 64'(rdy_a), 64'd0);
    do_start(16'd5);
    send_word(32'h0000_0008, 1, 0);
    wait_done("t2_done");
    chk("t2_hold_released", 64'(hold_a), 64'd0);
    chk("t2_busy_clear", 64'(busy_a), 64'd0);
    chk("t2_ready_clear", 64'(rdy_a), 64'd0);
    tick();
    drained("t2_drained");

    // 3: one word with random valid gaps
    do_start(16'd1);
    chk("t3_done_cleared", 64'(done_a), 64'd0);
    chk("t3_hold_back", 64'(hold_a), 64'd1);
    send_word(32'hDEAD_BEEF, 0, 3);
    wait_done("t3_done");
    tick();
    drained("t3_drained");

    // 4: zero-length load, then oversized rejected start
    do_start(16'd0);
    chk("t4_zero_done", 64'(done_a), 64'd1);
    chk("t4_zero_hold", 64'(hold_a), 64'd0);
    chk("t4_zero_busy", 64'(busy_a), 64'd0);
    tick();
    do_start(16'd1025);
    chk("t4_err_pulse", 64'(err_a), 64'd1);
    chk("t4_err_hold", 64'(hold_a), 64'd1);
    chk("t4_err_busy", 64'(busy_a), 64'd0);
    chk("t4_err_ready", 64'(rdy_a), 64'd0);
    tick();
    chk("t4_err_cleared", 64'(err_a), 64'd0);
    chk("t4_still_idle", 64'(busy_a), 64'd0);
    drained("t4_no_writes");

    // 5: reset mid-load discards the partial word
    do_start(16'd3);
    send_word(32'h1122_3344, 0, 1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    tick();
    do_reset(1);
    chk("t5_hold", 64'(hold_a), 64'd1);
    chk("t5_busy", 64'(busy_a), 64'd0);
    chk("t5_ready", 64'(rdy_a), 64'd0);
    chk("t5_done", 64'(done_a), 64'd0);
    drained("t5_one_write");
    do_start(16'd1);
    send_word(32'hCAFE_F00D, 0, 0);
    wait_done("t5_restart_done");
    tick();
    drained("t5_restart_drained");

    // 6: instance b wraps from 0xFFFFFFFC to 0x0
    do_start(16'd2);
    send_word(32'hA5A5_0001, 0, 0);
    send_word(32'h5A5A_0002, 1, 2);
    wait_done("t6_done");
    chk("t6_done_b", 64'(done_b), 64'd1);
    chk("t6_hold_b", 64'(hold_b), 64'd0);
    tick();
    drained("t6_drained");

    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
